// File: rtl/eth_header_inserter_if.sv
// Descriptor, payload-in and framed-out buses of the Ethernet header inserter.
// The slave modport is the inserter's view; master is its environment's view.
interface eth_header_inserter_if #(parameter int DATA_WIDTH = 64);
  localparam int KEEP_W = DATA_WIDTH / 8;

  logic                  s_hdr_valid;
  logic                  s_hdr_ready;
  logic [47:0]           s_hdr_dest_mac;
  logic [47:0]           s_hdr_src_mac;
  logic                  s_hdr_vlan_present;
  logic [11:0]           s_hdr_vlan_id;
  logic [15:0]           s_hdr_ethertype;

  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic [KEEP_W-1:0]     s_axis_tkeep;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic                  s_axis_tlast;

  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic [KEEP_W-1:0]     m_axis_tkeep;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;

  modport slave (
    input  s_hdr_valid, s_hdr_dest_mac, s_hdr_src_mac, s_hdr_vlan_present,
           s_hdr_vlan_id, s_hdr_ethertype,
    output s_hdr_ready,
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport master (
    output s_hdr_valid, s_hdr_dest_mac, s_hdr_src_mac, s_hdr_vlan_present,
           s_hdr_vlan_id, s_hdr_ethertype,
    input  s_hdr_ready,
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/eth_header_inserter.sv
// Prepends a 14/18-byte L2 header to a 64-bit AXI4-Stream payload, realigning
// payload bytes behind the header. Padding and FCS are left to the MAC.
module eth_header_inserter #(
  parameter int DATA_WIDTH = 64
) (
  input logic clk,
  input logic rst,
  eth_header_inserter_if.slave bus
);
  localparam int KEEP_W = DATA_WIDTH / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_PAY  = 2'd2;
  localparam logic [1:0] ST_TAIL = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  beat_q, beat_d;
  logic                  tagged_q, tagged_d;
  logic [47:0]           dest_q, dest_d;
  logic [47:0]           src_q, src_d;
  logic [11:0]           vid_q, vid_d;
  logic [15:0]           etype_q, etype_d;
  logic [47:0]           res_q, res_d;
  logic [3:0]            rcnt_q, rcnt_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [KEEP_W-1:0]     m_keep_q, m_keep_d;
  logic                  m_last_q, m_last_d;
  logic                  m_valid_q, m_valid_d;

  function automatic logic [47:0] swap48(input logic [47:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24], v[39:32], v[47:40]};
  endfunction

  function automatic logic [7:0] keep_lo(input logic [3:0] cnt);
    return 8'hFF >> (4'd8 - cnt);
  endfunction

  function automatic logic [63:0] mask_keep(input logic [63:0] d, input logic [7:0] k);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) if (k[i]) m[8*i +: 8] = 8'hFF;
    return d & m;
  endfunction

  // Header laid out lane-ordered: byte k of the wire header sits at [8k+7:8k].
  logic [15:0]  tci;
  logic [175:0] hdr_vec;
  assign tci = {4'b0, vid_q};
  always_comb begin
    if (tagged_q)
      hdr_vec = {32'b0, etype_q[7:0], etype_q[15:8], tci[7:0], tci[15:8], 16'h0081,
                 swap48(src_q), swap48(dest_q)};
    else
      hdr_vec = {64'b0, etype_q[7:0], etype_q[15:8], swap48(src_q), swap48(dest_q)};
  end

  logic        free;
  logic [3:0]  n_in;
  logic [3:0]  room;
  logic [3:0]  offs;
  logic [63:0] pay_data;
  logic [47:0] pay_res;

  assign free = !m_valid_q || bus.m_axis_tready;
  assign room = tagged_q ? 4'd6 : 4'd2;
  assign offs = tagged_q ? 4'd2 : 4'd6;

  always_comb begin
    n_in = '0;
    for (int i = 0; i < 8; i++) n_in = n_in + {3'b0, bus.s_axis_tkeep[i]};
  end

  always_comb begin
    if (tagged_q) begin
      pay_data = {bus.s_axis_tdata[47:0], res_q[15:0]};
      pay_res  = {32'b0, bus.s_axis_tdata[63:48]};
    end else begin
      pay_data = {bus.s_axis_tdata[15:0], res_q};
      pay_res  = bus.s_axis_tdata[63:16];
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    tagged_d  = tagged_q;
    dest_d    = dest_q;
    src_d     = src_q;
    vid_d     = vid_q;
    etype_d   = etype_q;
    res_d     = res_q;
    rcnt_d    = rcnt_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q && !bus.m_axis_tready;
    case (state_q)
      ST_IDLE: begin
        if (bus.s_hdr_valid) begin
          tagged_d = bus.s_hdr_vlan_present;
          dest_d   = bus.s_hdr_dest_mac;
          src_d    = bus.s_hdr_src_mac;
          vid_d    = bus.s_hdr_vlan_id;
          etype_d  = bus.s_hdr_ethertype;
          beat_d   = 1'b0;
          state_d  = ST_HDR;
        end
      end
      ST_HDR: begin
        if (free) begin
          m_data_d  = beat_q ? hdr_vec[127:64] : hdr_vec[63:0];
          m_keep_d  = 8'hFF;
          m_last_d  = 1'b0;
          m_valid_d = 1'b1;
          if (beat_q == tagged_q) begin
            res_d   = beat_q ? hdr_vec[175:128] : hdr_vec[111:64];
            state_d = ST_PAY;
          end else begin
            beat_d = 1'b1;
          end
        end
      end
      ST_PAY: begin
        if (free && bus.s_axis_tvalid) begin
          m_valid_d = 1'b1;
          res_d     = pay_res;
          m_data_d  = pay_data;
          m_keep_d  = 8'hFF;
          m_last_d  = 1'b0;
          if (bus.s_axis_tlast) begin
            if (n_in <= room) begin
              m_keep_d = keep_lo(offs + n_in);
              m_data_d = mask_keep(pay_data, keep_lo(offs + n_in));
              m_last_d = 1'b1;
              state_d  = ST_IDLE;
            end else begin
              rcnt_d  = n_in - room;
              state_d = ST_TAIL;
            end
          end
        end
      end
      default: begin
        if (free) begin
          m_data_d  = mask_keep({16'b0, res_q}, keep_lo(rcnt_q));
          m_keep_d  = keep_lo(rcnt_q);
          m_last_d  = 1'b1;
          m_valid_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      beat_q    <= 1'b0;
      tagged_q  <= 1'b0;
      dest_q    <= '0;
      src_q     <= '0;
      vid_q     <= '0;
      etype_q   <= '0;
      res_q     <= '0;
      rcnt_q    <= '0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      tagged_q  <= tagged_d;
      dest_q    <= dest_d;
      src_q     <= src_d;
      vid_q     <= vid_d;
      etype_q   <= etype_d;
      res_q     <= res_d;
      rcnt_q    <= rcnt_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign bus.s_hdr_ready   = (state_q == ST_IDLE);
  assign bus.s_axis_tready = (state_q == ST_PAY) && free;
  assign bus.m_axis_tdata  = m_data_q;
  assign bus.m_axis_tkeep  = m_keep_q;
  assign bus.m_axis_tlast  = m_last_q;
  assign bus.m_axis_tvalid = m_valid_q;
endmodule

// File: tb/tb_eth_header_inserter.sv
// Scoreboard bench for eth_header_inserter: drivers feed descriptor/payload queues,
// a frame-level byte model fills the expected-beat queue, a monitor pops and compares.
module tb_eth_header_inserter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eth_header_inserter_if #(.DATA_WIDTH(64)) bus();
  eth_header_inserter #(.DATA_WIDTH(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [47:0] dst;
    logic [47:0] src;
    logic        tag;
    logic [11:0] vid;
    logic [15:0] et;
  } desc_t;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  desc_t hdr_q[$];
  beat_t pay_q[$];
  beat_t exp_q[$];
  int    hs_edges[$];
  int    tlast_edges[$];
  int    first_edges[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    out_beats = 0;
  int    rdy_mode = 0;
  bit    gap_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] kmask(input logic [7:0] k);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) if (k[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  // Reference: the frame is just header bytes followed by payload bytes, cut into 8-byte beats.
  function automatic void model_frame(input desc_t d, input logic [7:0] p[$]);
    logic [7:0] b[$];
    for (int i = 5; i >= 0; i--) b.push_back(d.dst[8*i +: 8]);
    for (int i = 5; i >= 0; i--) b.push_back(d.src[8*i +: 8]);
    if (d.tag) begin
      b.push_back(8'h81);
      b.push_back(8'h00);
      b.push_back({4'h0, d.vid[11:8]});
      b.push_back(d.vid[7:0]);
    end
    b.push_back(d.et[15:8]);
    b.push_back(d.et[7:0]);
    foreach (p[i]) b.push_back(p[i]);
    for (int s = 0; s < b.size(); s += 8) begin
      beat_t e;
      e.data = '0;
      e.keep = '0;
      for (int k = 0; k < 8 && s + k < b.size(); k++) begin
        e.data[8*k +: 8] = b[s+k];
        e.keep[k] = 1'b1;
      end
      e.last = (s + 8 >= b.size());
      exp_q.push_back(e);
    end
  endfunction

  task automatic issue(input desc_t d, input logic [7:0] p[$], input bit use_model);
    hdr_q.push_back(d);
    for (int s = 0; s < p.size(); s += 8) begin
      beat_t b;
      b.data = {$urandom, $urandom};
      b.keep = '0;
      for (int k = 0; k < 8 && s + k < p.size(); k++) begin
        b.data[8*k +: 8] = p[s+k];
        b.keep[k] = 1'b1;
      end
      b.last = (s + 8 >= p.size());
      pay_q.push_back(b);
    end
    if (use_model) model_frame(d, p);
  endtask

  task automatic push_exp(input logic [63:0] d, input logic [7:0] k, input logic l);
    beat_t e;
    e.data = d;
    e.keep = k;
    e.last = l;
    exp_q.push_back(e);
  endtask

  function automatic desc_t rand_desc(input bit tag);
    desc_t d;
    logic [63:0] t;
    t = {$urandom, $urandom};
    d.dst = t[47:0];
    t = {$urandom, $urandom};
    d.src = t[47:0];
    t = {$urandom, $urandom};
    d.vid = t[11:0];
    d.et  = t[31:16];
    d.tag = tag;
    return d;
  endfunction

  task automatic rand_frame(input int len, input bit tag);
    logic [7:0] p[$];
    for (int i = 0; i < len; i++) p.push_back(8'($urandom));
    issue(rand_desc(tag), p, 1'b1);
  endtask

  task automatic scen_untagged();
    desc_t d;
    logic [7:0] p[$];
    d.dst = 48'h001122334455;
    d.src = 48'h66778899AABB;
    d.tag = 1'b0;
    d.vid = '0;
    d.et  = 16'h0800;
    for (int i = 0; i < 16; i++) p.push_back(8'(i));
    issue(d, p, 1'b0);
    push_exp(64'h7766554433221100, 8'hFF, 1'b0);
    push_exp(64'h01000008BBAA9988, 8'hFF, 1'b0);
    push_exp(64'h0908070605040302, 8'hFF, 1'b0);
    push_exp(64'h00000F0E0D0C0B0A, 8'h3F, 1'b1);
  endtask

  task automatic scen_tagged();
    desc_t d;
    logic [7:0] p[$];
    d.dst = 48'h001122334455;
    d.src = 48'h66778899AABB;
    d.tag = 1'b1;
    d.vid = 12'h123;
    d.et  = 16'h86DD;
    for (int i = 0; i < 7; i++) p.push_back(8'(8'hA0 + i));
    issue(d, p, 1'b0);
    push_exp(64'h7766554433221100, 8'hFF, 1'b0);
    push_exp(64'h23010081BBAA9988, 8'hFF, 1'b0);
    push_exp(64'hA5A4A3A2A1A0DD86, 8'hFF, 1'b0);
    push_exp(64'h00000000000000A6, 8'h01, 1'b1);
  endtask

  task automatic wait_done(input int limit, input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || hdr_q.size() != 0 || pay_q.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL %s_timeout: %0d beats still expected, required 0", tag, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_rst(input string tag);
    checks++;
    if ({bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast,
         bus.s_axis_tready, bus.s_hdr_ready} !== {1'b0, 64'h0, 8'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL %s: got v=%0b d=%h k=%h l=%0b str=%0b hr=%0b, required v=0 d=0 k=0 l=0 str=0 hr=1",
               tag, bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast,
               bus.s_axis_tready, bus.s_hdr_ready);
    end
  endtask

  initial begin : hdr_drv
    bus.s_hdr_valid        = 1'b0;
    bus.s_hdr_dest_mac     = '0;
    bus.s_hdr_src_mac      = '0;
    bus.s_hdr_vlan_present = 1'b0;
    bus.s_hdr_vlan_id      = '0;
    bus.s_hdr_ethertype    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || hdr_q.size() == 0) begin
        bus.s_hdr_valid = 1'b0;
      end else begin
        bus.s_hdr_valid        = 1'b1;
        bus.s_hdr_dest_mac     = hdr_q[0].dst;
        bus.s_hdr_src_mac      = hdr_q[0].src;
        bus.s_hdr_vlan_present = hdr_q[0].tag;
        bus.s_hdr_vlan_id      = hdr_q[0].vid;
        bus.s_hdr_ethertype    = hdr_q[0].et;
      end
      @(negedge clk);
      if (!rst && bus.s_hdr_valid && bus.s_hdr_ready && hdr_q.size() != 0) begin
        hs_edges.push_back(cyc + 1);
        void'(hdr_q.pop_front());
      end
    end
  end

  initial begin : pay_drv
    bit pending;
    pending = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tkeep  = '0;
    bus.s_axis_tlast  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) pending = 1'b0;
      if (!pending && !rst && pay_q.size() != 0 && !(gap_en && $urandom_range(0, 2) == 0))
        pending = 1'b1;
      if (pending) begin
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = pay_q[0].data;
        bus.s_axis_tkeep  = pay_q[0].keep;
        bus.s_axis_tlast  = pay_q[0].last;
      end else begin
        bus.s_axis_tvalid = 1'b0;
      end
      @(negedge clk);
      if (!rst && pending && bus.s_axis_tready && pay_q.size() != 0) begin
        void'(pay_q.pop_front());
        pending = 1'b0;
      end
    end
  end

  initial begin : rdy_drv
    bus.m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.m_axis_tready = 1'b1;
        1:       bus.m_axis_tready = ~bus.m_axis_tready;
        default: bus.m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin : monitor
    bit    prev_stall;
    bit    first;
    beat_t prev;
    prev_stall = 1'b0;
    first      = 1'b1;
    prev.data  = '0;
    prev.keep  = '0;
    prev.last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        first      = 1'b1;
        continue;
      end
      if (prev_stall) begin
        checks++;
        if (!bus.m_axis_tvalid || bus.m_axis_tdata !== prev.data ||
            bus.m_axis_tkeep !== prev.keep || bus.m_axis_tlast !== prev.last) begin
          errors++;
          $display("FAIL hold_stable: got v=%0b d=%h k=%h l=%0b, required v=1 d=%h k=%h l=%0b",
                   bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast,
                   prev.data, prev.keep, prev.last);
        end
      end
      if (bus.m_axis_tvalid && !prev_stall) begin
        if (bus.m_axis_tlast) tlast_edges.push_back(cyc);
        if (first) first_edges.push_back(cyc);
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        out_beats++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got d=%h k=%h l=%0b, required no beat",
                   bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if ((bus.m_axis_tdata & kmask(bus.m_axis_tkeep)) !== e.data ||
              bus.m_axis_tkeep !== e.keep || bus.m_axis_tlast !== e.last) begin
            errors++;
            $display("FAIL beat: got d=%h k=%h l=%0b, required d=%h k=%h l=%0b",
                     bus.m_axis_tdata & kmask(bus.m_axis_tkeep), bus.m_axis_tkeep,
                     bus.m_axis_tlast, e.data, e.keep, e.last);
          end
        end
        first = bus.m_axis_tlast;
      end
      prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
      prev.data  = bus.m_axis_tdata;
      prev.keep  = bus.m_axis_tkeep;
      prev.last  = bus.m_axis_tlast;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int base;
    int n;
    logic [7:0] p[$];
    #12;
    check_rst("reset_init");
    @(posedge clk);
    #1 rst = 1'b0;

    scen_untagged();
    wait_done(200, "untagged");
    scen_tagged();
    wait_done(200, "tagged");

    p.delete();
    p.push_back(8'hEE);
    p.push_back(8'hFF);
    issue(rand_desc(1'b0), p, 1'b1);
    wait_done(200, "short");

    rdy_mode = 1;
    gap_en   = 1'b1;
    rand_frame(64, 1'b0);
    wait_done(2000, "backpressure");
    rdy_mode = 0;
    gap_en   = 1'b0;

    hs_edges.delete();
    tlast_edges.delete();
    first_edges.delete();
    rand_frame(11, 1'b1);
    rand_frame(20, 1'b0);
    wait_done(400, "b2b");
    checks++;
    if (hs_edges.size() < 2 || first_edges[0] != hs_edges[0] + 1) begin
      errors++;
      $display("FAIL first_beat_latency: got edge %0d, required %0d", first_edges[0], hs_edges[0] + 1);
    end
    checks++;
    if (hs_edges.size() < 2 || tlast_edges.size() < 1 || hs_edges[1] != tlast_edges[0] + 1) begin
      errors++;
      $display("FAIL b2b_hdr_handshake: got edge %0d, required %0d", hs_edges[1], tlast_edges[0] + 1);
    end
    checks++;
    if (first_edges.size() < 2 || first_edges[1] != hs_edges[1] + 1) begin
      errors++;
      $display("FAIL b2b_second_header: got edge %0d, required %0d", first_edges[1], hs_edges[1] + 1);
    end

    base = out_beats;
    scen_untagged();
    n = 0;
    while (!(out_beats >= base + 2 && bus.m_axis_tvalid) && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL mid_reset_wait: got %0d beats, required 2", out_beats - base);
    end
    rst = 1'b1;
    hdr_q.delete();
    pay_q.delete();
    exp_q.delete();
    #1;
    check_rst("reset_mid");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    scen_untagged();
    wait_done(200, "replay");

    for (int b = 0; b < 4; b++) begin
      rdy_mode = b % 3;
      gap_en   = (b >= 2);
      for (int f = 0; f < 6; f++) rand_frame($urandom_range(1, 40), 1'($urandom_range(0, 1)));
      wait_done(5000, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/eth_header_inserter.md
# eth_header_inserter

Transmit-side counterpart of the Ethernet frame parser. It accepts one header descriptor per frame (destination MAC, source MAC, optional 802.1Q tag, EtherType) and a payload AXI4-Stream. It emits a single AXI4-Stream frame with the 14- or 18-byte L2 header prepended, realigning the payload across 64-bit beats. It sits between the TX packet builder and the MAC, which appends padding and FCS; this block does neither.

## Interface
- DATA_WIDTH, 64, stream width in bits; only 64 is supported.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- s_hdr_valid  in  1  header descriptor valid.
- s_hdr_ready  out  1  header descriptor accepted on valid&ready.
- s_hdr_dest_mac  in  48  destination MAC; [47:40] is the first byte on the wire.
- s_hdr_src_mac  in  48  source MAC, same byte order.
- s_hdr_vlan_present  in  1  insert an 802.1Q tag.
- s_hdr_vlan_id  in  12  VID; the TCI is {4'b0, vlan_id}, so PCP and DEI are 0.
- s_hdr_ethertype  in  16  EtherType/length; [15:8] is sent first.
- s_axis_tdata / tkeep / tvalid / tready / tlast  in/in/in/out/in  64/8/1/1/1  payload stream.
- m_axis_tdata / tkeep / tvalid / tready / tlast  out/out/out/in/out  64/8/1/1/1  framed output stream.

## Operation
- Byte lane n is tdata[8n+7:8n]; lane 0 is the earliest byte on the wire.
- Payload tkeep rules:
  - Non-last beats: 0xFF.
  - Last beat: contiguous from lane 0, with n = popcount 1..8.
  - Payload is at least 1 byte. Non-conforming input is undefined.
- Header bytes, in order:
  - dest MAC[47:0].
  - src MAC[47:0].
  - If tagged: 0x81, 0x00, TCI[15:8], TCI[7:0].
  - EtherType[15:8], EtherType[7:0].
- H = 14 (untagged) or 18 (tagged). Offset O = H mod 8 = 6 or 2, latched per frame.
- State machine:
  - IDLE:
    - s_hdr_ready=1.
    - On s_hdr_valid: latch the descriptor and go to HDR with beat count 0.
  - HDR:
    - Each time the output register is free, emit header bytes [8k..8k+7] with tkeep=0xFF and tlast=0.
    - After beat H/8-1 (beat 0 if untagged, beat 1 if tagged), load the residual register with header bytes 8·(H/8)..H-1 (O bytes).
    - Go to PAYLOAD.
  - PAYLOAD:
    - Output beat = residual (lanes 0..O-1) plus input lanes 0..7-O placed in lanes O..7.
    - Then residual <= input lanes 8-O..7.
    - On tlast with n ≤ 8-O: tkeep = low (O+n) bits set, tlast=1, go to IDLE.
    - On tlast with n > 8-O: tkeep=0xFF, tlast=0, remaining r = n-(8-O) bytes stay in the residual, go to TAIL.
  - TAIL:
    - When the output register is free, emit the residual in lanes 0..r-1 with tkeep = low r bits and tlast=1.
    - Go to IDLE.
- Output length is always H + payload bytes.
- The payload is never reordered, duplicated or dropped.

## Timing
- All m_axis_* outputs are registered.
- The output register is free when !m_axis_tvalid || m_axis_tready.
- While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata/tkeep/tlast hold stable.
- s_axis_tready = (state==PAYLOAD) && free. It is 0 in IDLE, HDR and TAIL.
- s_hdr_ready = (state==IDLE) and does not depend on s_hdr_valid.
- Latency:
  - Descriptor accepted at edge N → first header beat has m_axis_tvalid=1 after edge N+1.
  - In PAYLOAD with m_axis_tready held high, one input beat produces one output beat per cycle.
- Between frames there is a minimum of 1 cycle in IDLE. The next descriptor can be accepted in the cycle after the last beat is loaded into the output register.
- The payload stream may arrive before the descriptor; it is stalled until PAYLOAD.
- Reset values:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0.
  - s_axis_tready=0, s_hdr_ready=1 (state IDLE).
  - Residual register and latched descriptor cleared.
- Reset mid-frame:
  - The frame is aborted immediately and the output beat is discarded with no tlast.
  - Upstream must also flush the rest of its payload.
  - The next descriptor starts a clean frame.

## Test plan
- Untagged frame.
  - Stimulus: dest 00:11:22:33:44:55, src 66:77:88:99:AA:BB, EtherType 0x0800, payload 0x00..0x0F in 2 beats, m_axis_tready=1.
  - Response: 4 beats:
    - 0x7766554433221100 (tkeep 0xFF).
    - 0x01000008BBAA9988 (tkeep 0xFF).
    - 0x0908070605040302 (tkeep 0xFF).
    - 0x00000F0E0D0C0B0A with tkeep 0x3F, tlast.
- Tagged frame with TAIL.
  - Stimulus: same MACs, VID 0x123, EtherType 0x86DD, payload A0..A6 in one beat with tkeep 0x7F.
  - Response:
    - Beat 0: 0x7766554433221100.
    - Beat 1: 0x23010081BBAA9988.
    - Beat 2: 0xA5A4A3A2A1A0DD86 (tkeep 0xFF).
    - Beat 3: 0xA6 with tkeep 0x01, tlast.
- Short untagged payload.
  - Stimulus: 2-byte payload 0xEE,0xFF with tkeep 0x03.
  - Response: beat 1 carries tkeep 0xFF and tlast, with lanes 6,7 = EE,FF. There is no TAIL beat. Total 16 bytes.
- Backpressure.
  - Stimulus: 64-byte untagged payload; m_axis_tready toggles 1/0 every cycle; s_axis_tvalid is randomly gapped.
  - Response: output byte stream equals the header plus payload (78 bytes). m_axis_* are stable whenever valid&!ready. There are no drops or duplicates.
- Back-to-back frames.
  - Stimulus: two descriptors with s_hdr_valid held high.
  - Response: the second s_hdr_ready handshake occurs exactly 1 cycle after the first frame's tlast beat is registered. The second frame's header follows on the next edge.
- Reset mid-frame.
  - Stimulus: assert rst during beat 2 of the first scenario, then release and replay that scenario.
  - Response: all outputs take their reset values immediately. The replayed frame matches the first scenario exactly.
